phy_tx_scheduler: RTL and testbench
===================================

# phy_tx_scheduler

- Word-rate transmit scheduler at the front of the PCIe PHY transmit path.
- On link enable, sends a fixed run of COM alignment words (K28.5 in every byte).
- Then shares the 32-bit PHY transmit input between two requesters: round-robin arbitration with a bounded burst length; idle COM words fill slots when neither requester has data.
- Its `phy_data`/`phy_valid` outputs drive the PHY's `data_in`/`valid_in` inputs directly.

## Interface

Parameters:
- DATA_W, 32, word width of requesters and PHY input
- ALIGN_WORDS, 4, number of COM words sent after enable before data (≥1)
- COM_WORD, 32'hBCBC_BCBC, alignment/idle fill word
- MAX_BURST, 8, max consecutive words granted to one requester while the other is waiting (≥1)

Ports:
- clk_2f  in  1  word-rate clock; all logic on posedge
- reset  in  1  synchronous, active-high
- enable  in  1  link enable; low forces IDLE
- req0_data  in  DATA_W  requester 0 word
- req0_valid  in  1  requester 0 has a word
- req0_ready  out  1  requester 0 word accepted this cycle (combinational)
- req1_data  in  DATA_W  requester 1 word
- req1_valid  in  1  requester 1 has a word
- req1_ready  out  1  requester 1 word accepted this cycle (combinational)
- phy_data  out  DATA_W  registered word to PHY
- phy_valid  out  1  registered valid to PHY
- aligned  out  1  registered; high while in RUN
- grant  out  1  registered; requester that owns the current burst

## Operation

- Reset values: state IDLE, phy_data=COM_WORD, phy_valid=0, aligned=0, grant=0, burst_cnt=0, align_cnt=0.
- Reset has priority over all other inputs.

States:
- IDLE:
  - phy_data<=COM_WORD, phy_valid<=0, aligned<=0.
  - Both readies are 0.
  - enable=1 → ALIGN with align_cnt<=0.
- ALIGN:
  - Each edge: phy_data<=COM_WORD, phy_valid<=1, align_cnt++.
  - On the edge where align_cnt reaches ALIGN_WORDS-1 → RUN, aligned<=1, burst_cnt<=0.
  - Readies are 0.
- RUN:
  - Arbitrate every cycle (below).
  - enable=0 → IDLE on that edge: no transfer that cycle, readies 0 combinationally, aligned<=0.

Arbitration (RUN and enable=1, combinational select `sel`):
- Neither valid: no transfer; phy_data<=COM_WORD, phy_valid<=0, burst_cnt<=0, grant held.
- Exactly one valid: sel = that requester.
- Both valid:
  - sel = grant if burst_cnt < MAX_BURST.
  - Otherwise sel = ~grant.
- reqN_ready = (sel==N) and transfer occurs. It never asserts without the matching valid.
- On transfer:
  - phy_data<=req_sel_data, phy_valid<=1.
  - If sel==grant: burst_cnt<=burst_cnt+1, saturating at MAX_BURST.
  - Otherwise: grant<=sel, burst_cnt<=1.
- burst_cnt width is clog2(MAX_BURST+1). align_cnt width is clog2(ALIGN_WORDS).
- Re-assertion of enable after IDLE always repeats the full ALIGN sequence.

## Timing

- Enable sampled high at edge E0 (IDLE→ALIGN).
- Edges E1..E_ALIGN_WORDS load COM_WORD with phy_valid=1; the last of these enters RUN and sets aligned=1.
- First possible ready is in the cycle after E_ALIGN_WORDS. That word appears on phy_data after the next edge.
- Latency from accepted word to phy_data: 1 cycle. Back-to-back transfers give one word per cycle, with no bubbles on grant switch.
- enable dropping mid-burst:
  - Readies drop in the same cycle.
  - phy_valid=0 and COM_WORD after the next edge.
  - The in-flight registered word, already accepted, is still presented for its one cycle.
- Reset mid-operation: all outputs return to reset values after the edge; the ALIGN sequence must be redone.

## Test plan

- Reset, then enable=1 with both requesters idle → exactly 4 cycles of phy_data=BCBC_BCBC/phy_valid=1, then aligned=1, then phy_valid=0 with COM fill; readies low throughout ALIGN.
- Only req0 valid with 32'hABFD_1234 continuously → every cycle req0_ready=1; phy_data=ABFD_1234, phy_valid=1, one cycle after acceptance; grant stays 0.
- Both valid continuously (req0 = FFFF_FFFF, req1 = EEEE_EEEE) → 8 words FFFF_FFFF, then 8 words EEEE_EEEE, repeating; grant toggles after each 8-word burst.
- req0 drops valid for one cycle mid-burst while req1 is valid → req1 granted that cycle with burst_cnt=1; when both are valid afterwards, req1 keeps the grant for up to 8 words.
- enable deasserted during RUN with data flowing → readies 0 in the same cycle; after one edge, phy_valid=0 and aligned=0; on re-enable, 4 COM words precede new data.
- reset asserted during ALIGN and again during RUN → next cycle phy_data=BCBC_BCBC, phy_valid=0, grant=0, aligned=0; a stale requester valid is not accepted.

Source files
------------

// File: rtl/phy_tx_scheduler.sv
// Word-rate PCIe PHY transmit scheduler: COM alignment run after enable, then
// round-robin sharing of the PHY input between two requesters with bounded bursts.
module phy_tx_scheduler #(
   parameter int                DATA_W      = 32,
   parameter int                ALIGN_WORDS = 4,
   parameter logic [DATA_W-1:0] COM_WORD    = 32'hBCBC_BCBC,
   parameter int                MAX_BURST   = 8
) (
   input  logic              clk_2f,
   input  logic              reset,
   input  logic              enable,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req1_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   output logic [DATA_W-1:0] phy_data,
   output logic              phy_valid,
   output logic              aligned,
   output logic              grant
);

   localparam int ACW = (ALIGN_WORDS > 1) ? $clog2(ALIGN_WORDS) : 1;
   localparam int BCW = $clog2(MAX_BURST + 1);
   localparam logic [ACW-1:0] ALIGN_LAST = ACW'(ALIGN_WORDS - 1);
   localparam logic [BCW-1:0] BURST_MAX  = BCW'(MAX_BURST);

   typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

   state_t            state_q, state_d;
   logic [ACW-1:0]    align_cnt_q, align_cnt_d;
   logic [BCW-1:0]    burst_cnt_q, burst_cnt_d;
   logic [DATA_W-1:0] phy_data_q, phy_data_d;
   logic              phy_valid_q, phy_valid_d;
   logic              aligned_q, aligned_d;
   logic              grant_q, grant_d;
   logic              sel;
   logic              xfer;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case statements can leave a value held (no latches).
   always_comb begin
      state_d     = state_q;
      align_cnt_d = align_cnt_q;
      burst_cnt_d = burst_cnt_q;
      phy_data_d  = phy_data_q;
      phy_valid_d = phy_valid_q;
      aligned_d   = aligned_q;
      grant_d     = grant_q;
      sel         = grant_q;
      xfer        = 1'b0;

      case (state_q)
         IDLE: begin
            phy_data_d  = COM_WORD;
            phy_valid_d = 1'b0;
            aligned_d   = 1'b0;
            if (enable) begin
               state_d     = ALIGN;
               align_cnt_d = '0;
            end
         end
         ALIGN: begin
            if (!enable) begin
               state_d     = IDLE;
               phy_data_d  = COM_WORD;
               phy_valid_d = 1'b0;
               aligned_d   = 1'b0;
            end else begin
               phy_data_d  = COM_WORD;
               phy_valid_d = 1'b1;
               if (align_cnt_q == ALIGN_LAST) begin
                  state_d     = RUN;
                  aligned_d   = 1'b1;
                  burst_cnt_d = '0;
               end else begin
                  align_cnt_d = align_cnt_q + 1'b1;
               end
            end
         end
         RUN: begin
            if (!enable) begin
               state_d     = IDLE;
               phy_data_d  = COM_WORD;
               phy_valid_d = 1'b0;
               aligned_d   = 1'b0;
            end else begin
               // The current owner keeps the slot until its burst is used up
               // while the other requester is waiting.
               if (req0_valid && req1_valid)
                  sel = (burst_cnt_q < BURST_MAX) ? grant_q : ~grant_q;
               else if (req0_valid)
                  sel = 1'b0;
               else if (req1_valid)
                  sel = 1'b1;
               xfer = (req0_valid || req1_valid) && !reset;

               if (xfer) begin
                  phy_data_d  = sel ? req1_data : req0_data;
                  phy_valid_d = 1'b1;
                  if (sel == grant_q) begin
                     if (burst_cnt_q != BURST_MAX)
                        burst_cnt_d = burst_cnt_q + 1'b1;
                  end else begin
                     grant_d     = sel;
                     burst_cnt_d = BCW'(1);
                  end
               end else begin
                  phy_data_d  = COM_WORD;
                  phy_valid_d = 1'b0;
                  burst_cnt_d = '0;
               end
            end
         end
         default: begin
            state_d     = IDLE;
            phy_data_d  = COM_WORD;
            phy_valid_d = 1'b0;
            aligned_d   = 1'b0;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments only; reset is synchronous and
   // wins over every other input.
   always_ff @(posedge clk_2f) begin
      if (reset) begin
         state_q     <= IDLE;
         align_cnt_q <= '0;
         burst_cnt_q <= '0;
         phy_data_q  <= COM_WORD;
         phy_valid_q <= 1'b0;
         aligned_q   <= 1'b0;
         grant_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         align_cnt_q <= align_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         phy_data_q  <= phy_data_d;
         phy_valid_q <= phy_valid_d;
         aligned_q   <= aligned_d;
         grant_q     <= grant_d;
      end
   end

   assign req0_ready = xfer && !sel;
   assign req1_ready = xfer && sel;
   assign phy_data   = phy_data_q;
   assign phy_valid  = phy_valid_q;
   assign aligned    = aligned_q;
   assign grant      = grant_q;

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Self-checking bench for phy_tx_scheduler: a cycle model queues the expected
// registered outputs each cycle; they are compared when the DUT presents them.
module tb_phy_tx_scheduler;

   localparam int          DW  = 32;
   localparam int          AW  = 4;
   localparam int          MB  = 8;
   localparam logic [31:0] COM = 32'hBCBC_BCBC;

   logic          clk_2f = 1'b0;
   logic          reset;
   logic          enable;
   logic [DW-1:0] req0_data, req1_data;
   logic          req0_valid, req1_valid;
   logic          req0_ready, req1_ready;
   logic [DW-1:0] phy_data;
   logic          phy_valid, aligned, grant;

   phy_tx_scheduler #(
      .DATA_W(DW), .ALIGN_WORDS(AW), .COM_WORD(COM), .MAX_BURST(MB)
   ) dut (
      .clk_2f(clk_2f), .reset(reset), .enable(enable),
      .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
      .phy_data(phy_data), .phy_valid(phy_valid), .aligned(aligned), .grant(grant)
   );

   always #5 clk_2f = ~clk_2f;

   typedef struct {
      logic [DW-1:0] data;
      logic          valid;
      logic          aligned;
      logic          grant;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] seen[$];
   int            n_checks = 0;
   int            n_errors = 0;
   int            com_cnt  = 0;
   bit            rec      = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: 0 = idle, 1 = aligning, 2 = running
   int            m_st    = 0;
   int            m_cnt   = 0;
   int            m_burst = 0;
   logic          m_grant = 1'b0;
   logic [DW-1:0] m_data  = COM;
   logic          m_valid = 1'b0;
   logic          m_align = 1'b0;

   always @(negedge clk_2f) begin
      exp_t e;
      logic m_xfer, m_sel;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("phy_data",  64'(phy_data),  64'(e.data));
         check("phy_valid", 64'(phy_valid), 64'(e.valid));
         check("aligned",   64'(aligned),   64'(e.aligned));
         check("grant",     64'(grant),     64'(e.grant));
      end
      if (phy_valid && phy_data == COM) com_cnt++;
      if (rec && phy_valid) seen.push_back(phy_data);

      m_xfer = 1'b0;
      m_sel  = m_grant;
      if (!reset && enable && m_st == 2 && (req0_valid || req1_valid)) begin
         m_xfer = 1'b1;
         if (req0_valid && req1_valid) m_sel = (m_burst >= MB) ? !m_grant : m_grant;
         else                          m_sel = req1_valid;
      end
      check("req0_ready", 64'(req0_ready), 64'(m_xfer && !m_sel));
      check("req1_ready", 64'(req1_ready), 64'(m_xfer && m_sel));

      if (reset) begin
         m_st = 0; m_cnt = 0; m_burst = 0; m_grant = 1'b0;
         m_data = COM; m_valid = 1'b0; m_align = 1'b0;
      end else if (m_st == 0) begin
         m_data = COM; m_valid = 1'b0; m_align = 1'b0;
         if (enable) begin m_st = 1; m_cnt = 0; end
      end else if (!enable) begin
         m_st = 0; m_data = COM; m_valid = 1'b0; m_align = 1'b0;
      end else if (m_st == 1) begin
         m_data = COM; m_valid = 1'b1;
         if (m_cnt == AW - 1) begin m_st = 2; m_align = 1'b1; m_burst = 0; end
         else m_cnt++;
      end else if (m_xfer) begin
         m_data  = m_sel ? req1_data : req0_data;
         m_valid = 1'b1;
         if (m_sel == m_grant) m_burst = (m_burst < MB) ? m_burst + 1 : MB;
         else begin m_grant = m_sel; m_burst = 1; end
      end else begin
         m_data = COM; m_valid = 1'b0; m_burst = 0;
      end
      exp_q.push_back('{data: m_data, valid: m_valid, aligned: m_align, grant: m_grant});
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_2f);
      #1;
   endtask

   initial begin
      int c0, base;
      reset = 1'b1; enable = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_data = 32'hABFD_1234; req1_data = 32'hEEEE_EEEE;
      tick(3);
      reset = 1'b0;
      tick(2);

      // Alignment run with both requesters idle
      c0 = com_cnt;
      enable = 1'b1;
      tick(10);
      check("align_com_words", 64'(com_cnt - c0), 64'(AW));

      // Single requester streaming
      req0_valid = 1'b1;
      tick(10);
      req0_valid = 1'b0;
      tick(1);

      // Both requesters streaming: 8/8 round robin
      req0_data = 32'hFFFF_FFFF;
      base = seen.size();
      rec = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      tick(40);
      rec = 1'b0;
      for (int i = 0; i < 3 * MB; i++)
         check($sformatf("burst_word%0d", i), 64'(seen[base + i]),
               64'(((i / MB) % 2 == 0) ? 32'hFFFF_FFFF : 32'hEEEE_EEEE));

      // req0 drops for one cycle mid-burst
      req0_valid = 1'b0;
      tick(1);
      req0_valid = 1'b1;
      tick(12);

      // Enable drop with data flowing, then re-enable
      enable = 1'b0;
      tick(3);
      c0 = com_cnt;
      enable = 1'b1;
      tick(10);
      check("realign_com_words", 64'(com_cnt - c0), 64'(AW));

      // Reset during RUN, then during ALIGN, then during RUN again
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      c0 = com_cnt;
      tick(8);
      check("reset_realign_com", 64'(com_cnt - c0), 64'(AW));
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(3);
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
